rs_issue_scheduler: RTL and testbench
=====================================

// Module: rs_issue_scheduler
// PURPOSE
//  Issue scheduler between the reservation station entries and the shared functional units.
//  Each cycle it picks the oldest ready ALU entry and the oldest ready MUL entry, by ROB age.
//  It sequences the non-pipelined multiplier, which is busy for MUL_LATENCY cycles per op.
//  It reserves the CDB slot so ALU and MUL results never collide, and drives the CDB source select.
// PARAMETERS
//  NUM_ENTRIES    8  number of reservation station entries scheduled
//  ROB_IDX_WIDTH  5  ROB index width; ROB depth is 2**ROB_IDX_WIDTH
//  MUL_LATENCY    3  cycles from MUL issue to MUL result on CDB; legal range 2..8
// PORTS
//  clk             in   1                          clock
//  rst             in   1                          synchronous active-high reset
//  flush           in   1                          squash all in-flight work (branch mispredict)
//  entry_valid     in   NUM_ENTRIES                entry holds a dispatched instruction
//  entry_rs1_ready in   NUM_ENTRIES                rs1 operand captured
//  entry_rs2_ready in   NUM_ENTRIES                rs2 operand captured
//  entry_is_mul    in   NUM_ENTRIES                1 = mul/div op type, 0 = alu op type
//  entry_rob_idx   in   NUM_ENTRIES*ROB_IDX_WIDTH  rd_rob_idx per entry; entry i at [i*W +: W]
//  rob_head        in   ROB_IDX_WIDTH              ROB head index (oldest instruction)
//  alu_issue_valid out  1                          ALU grant this cycle
//  alu_issue_idx   out  $clog2(NUM_ENTRIES)        granted ALU entry
//  mul_issue_valid out  1                          MUL grant this cycle
//  mul_issue_idx   out  $clog2(NUM_ENTRIES)        granted MUL entry
//  issue_clear     out  NUM_ENTRIES                entries to free at the next edge (OR of both grants)
//  mul_busy        out  1                          multiplier occupied
//  cdb_src_sel     out  2                          CDB owner: 00 none, 01 ALU, 10 MUL; 11 never driven
// BEHAVIOUR
//  - Eligibility: cand[i] = entry_valid & rs1_ready & rs2_ready. ALU ports take is_mul = 0, MUL takes is_mul = 1.
//  - Age: age_i = (entry_rob_idx_i - rob_head) mod 2**ROB_IDX_WIDTH. The smallest age wins.
//    Equal ages resolve to the lowest entry index.
//  - Grants are combinational from current inputs and state. The RS frees entries flagged in issue_clear at the next posedge.
//  - MUL FSM
//    - States: IDLE and BUSY, with a down-counter mul_cnt.
//    - IDLE: a MUL grant is allowed. A grant in cycle t moves the FSM to BUSY with mul_cnt = MUL_LATENCY-1.
//    - BUSY: mul_busy = 1 and mul_cnt decrements each cycle. At mul_cnt == 1 the FSM returns to IDLE on the next edge.
//    - So mul_busy is high for cycles t+1 .. t+MUL_LATENCY-1, and the next MUL grant is possible at t+MUL_LATENCY.
//  - CDB reservation
//    - Shift register res[MUL_LATENCY-1:0]. A MUL grant at t sets a bit so that cdb_src_sel = 10 in cycle t+MUL_LATENCY.
//    - An ALU grant at t gives cdb_src_sel = 01 in cycle t+1.
//    - The ALU grant is suppressed in any cycle where the following cycle is MUL-reserved. ALU candidates wait; none is dropped.
//  - cdb_src_sel is a registered output.
//  - Both ports may grant in the same cycle when both have candidates and no conflict exists.
//  - Flush
//    - While flush = 1 there are no grants and issue_clear = 0.
//    - On the flush edge: FSM -> IDLE, mul_cnt = 0, res = 0, cdb_src_sel = 00 from the next cycle.
//    - The in-flight MUL result is squashed (never claims the CDB).
//  - rst has priority over flush and does the same clear.
//    Reset values: all outputs 0, FSM IDLE, counters and reservation bits 0.
//  - Reset mid-operation abandons any MUL in progress, and no stale reservation survives.
//  - With no candidates for a port, its valid = 0 and its idx = 0.
//  - ROB wrap: age arithmetic is modulo and is correct when rob_idx < rob_head numerically.
// TESTING
//  - Reset: hold rst 2 cycles with all entries ready -> every output 0; first grants one cycle after rst drops.
//  - Age select
//    - Setup: head = 30; entries 2 (rob 1), 5 (rob 31), 6 (rob 29), all ALU ready.
//    - Response: grant idx 5 (age 1); clearing it next grants 2 (age 3); idx 6 (age 31) is last.
//  - Tie: entries 3 and 4 with equal rob_idx -> idx 3 granted first.
//  - MUL sequencing
//    - Stimulus: two MUL entries ready at t = 0, MUL_LATENCY = 3.
//    - Response: grants at t = 0 and t = 3; mul_busy at t = 1, 2 and 4, 5; cdb_src_sel = 10 at t = 3 and 6.
//  - Collision
//    - Stimulus: MUL granted at t = 0; an ALU entry is ready every cycle.
//    - Response: ALU grants at t = 0, 1, none at t = 2, grant again at t = 3; cdb_src_sel = 01 at t = 1, 2, 10 at t = 3, 01 at t = 4.
//  - Flush: flush at t = 1 after a MUL grant at t = 0 -> no grant at t = 1; cdb_src_sel = 00 at t = 3; mul_busy = 0 from t = 2.

Source files
------------

// File: rtl/rs_issue_scheduler.sv
// Issue scheduler: oldest-ready ALU/MUL selection by ROB age, multiplier sequencing
// and CDB slot reservation so ALU and MUL writebacks never collide.
module rs_issue_scheduler #(
  parameter int unsigned NUM_ENTRIES   = 8,
  parameter int unsigned ROB_IDX_WIDTH = 5,
  parameter int unsigned MUL_LATENCY   = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [NUM_ENTRIES-1:0]                 entry_valid,
  input  logic [NUM_ENTRIES-1:0]                 entry_rs1_ready,
  input  logic [NUM_ENTRIES-1:0]                 entry_rs2_ready,
  input  logic [NUM_ENTRIES-1:0]                 entry_is_mul,
  input  logic [NUM_ENTRIES*ROB_IDX_WIDTH-1:0]   entry_rob_idx,
  input  logic [ROB_IDX_WIDTH-1:0]               rob_head,
  output logic                                   alu_issue_valid,
  output logic [$clog2(NUM_ENTRIES)-1:0]         alu_issue_idx,
  output logic                                   mul_issue_valid,
  output logic [$clog2(NUM_ENTRIES)-1:0]         mul_issue_idx,
  output logic [NUM_ENTRIES-1:0]                 issue_clear,
  output logic                                   mul_busy,
  output logic [1:0]                             cdb_src_sel
);

  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
  localparam int unsigned CntW = $clog2(MUL_LATENCY);
  localparam int unsigned ResW = MUL_LATENCY - 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [ResW-1:0]          res_q, res_d;
  logic [1:0]               cdb_q, cdb_d;

  logic [NUM_ENTRIES-1:0]   cand;
  logic [NUM_ENTRIES-1:0]   alu_cand;
  logic [NUM_ENTRIES-1:0]   mul_cand;
  logic                     alu_found, mul_found;
  logic [IdxW-1:0]          alu_sel, mul_sel;
  logic [ROB_IDX_WIDTH-1:0] alu_age, mul_age, age_tmp;
  logic                     grant_ok;

  assign cand     = entry_valid & entry_rs1_ready & entry_rs2_ready;
  assign alu_cand = cand & ~entry_is_mul;
  assign mul_cand = cand & entry_is_mul;

  // Strict less-than keeps the lowest index on equal ages.
  always_comb begin
    alu_found = 1'b0;
    mul_found = 1'b0;
    alu_sel   = '0;
    mul_sel   = '0;
    alu_age   = '0;
    mul_age   = '0;
    age_tmp   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      age_tmp = entry_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] - rob_head;
      if (alu_cand[i] && (!alu_found || (age_tmp < alu_age))) begin
        alu_found = 1'b1;
        alu_age   = age_tmp;
        alu_sel   = IdxW'(i);
      end
      if (mul_cand[i] && (!mul_found || (age_tmp < mul_age))) begin
        mul_found = 1'b1;
        mul_age   = age_tmp;
        mul_sel   = IdxW'(i);
      end
    end
  end

  assign grant_ok = !rst && !flush;

  // res_q[0] set means the CDB is owned by the multiplier next cycle.
  always_comb begin
    alu_issue_valid = alu_found && grant_ok && !res_q[0];
    mul_issue_valid = mul_found && grant_ok && (state_q == StIdle);
    alu_issue_idx   = alu_issue_valid ? alu_sel : '0;
    mul_issue_idx   = mul_issue_valid ? mul_sel : '0;
    issue_clear     = '0;
    if (alu_issue_valid) begin
      issue_clear = issue_clear | (NUM_ENTRIES'(1) << alu_issue_idx);
    end
    if (mul_issue_valid) begin
      issue_clear = issue_clear | (NUM_ENTRIES'(1) << mul_issue_idx);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mul_issue_valid) begin
          state_d = StBusy;
          cnt_d   = CntW'(MUL_LATENCY - 1);
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_comb begin
    res_d = res_q >> 1;
    if (mul_issue_valid) begin
      res_d = res_d | (ResW'(1) << (ResW - 1));
    end
    if (res_q[0]) begin
      cdb_d = 2'b10;
    end else if (alu_issue_valid) begin
      cdb_d = 2'b01;
    end else begin
      cdb_d = 2'b00;
    end
    // A squashed multiply must not claim its reserved slot.
    if (flush) begin
      res_d = '0;
      cdb_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      res_q   <= '0;
      cdb_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cdb_q   <= cdb_d;
    end
  end

  assign mul_busy    = (state_q == StBusy);
  assign cdb_src_sel = cdb_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler with hand-computed expectations.
module tb_rs_issue_scheduler;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [7:0]  entry_valid;
  logic [7:0]  entry_rs1_ready;
  logic [7:0]  entry_rs2_ready;
  logic [7:0]  entry_is_mul;
  logic [39:0] entry_rob_idx;
  logic [4:0]  rob_head;
  logic        alu_issue_valid;
  logic [2:0]  alu_issue_idx;
  logic        mul_issue_valid;
  logic [2:0]  mul_issue_idx;
  logic [7:0]  issue_clear;
  logic        mul_busy;
  logic [1:0]  cdb_src_sel;

  int n_checks = 0;
  int n_errors = 0;

  rs_issue_scheduler #(
    .NUM_ENTRIES  (8),
    .ROB_IDX_WIDTH(5),
    .MUL_LATENCY  (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .entry_valid    (entry_valid),
    .entry_rs1_ready(entry_rs1_ready),
    .entry_rs2_ready(entry_rs2_ready),
    .entry_is_mul   (entry_is_mul),
    .entry_rob_idx  (entry_rob_idx),
    .rob_head       (rob_head),
    .alu_issue_valid(alu_issue_valid),
    .alu_issue_idx  (alu_issue_idx),
    .mul_issue_valid(mul_issue_valid),
    .mul_issue_idx  (mul_issue_idx),
    .issue_clear    (issue_clear),
    .mul_busy       (mul_busy),
    .cdb_src_sel    (cdb_src_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_all();
    entry_valid     = '0;
    entry_rs1_ready = '0;
    entry_rs2_ready = '0;
    entry_is_mul    = '0;
    entry_rob_idx   = '0;
  endtask

  task automatic set_entry(input int i, input logic v, input logic m, input int r);
    entry_valid[i]            = v;
    entry_rs1_ready[i]        = 1'b1;
    entry_rs2_ready[i]        = 1'b1;
    entry_is_mul[i]           = m;
    entry_rob_idx[i*5 +: 5]   = 5'(r);
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    rob_head = '0;
    clr_all();
    for (int i = 0; i < 8; i++) set_entry(i, 1'b1, 1'b0, i);

    // Reset held for two edges with every entry ready
    @(negedge clk); @(negedge clk); #1;
    check("rst_alu_v", alu_issue_valid, 0);
    check("rst_alu_idx", alu_issue_idx, 0);
    check("rst_mul_v", mul_issue_valid, 0);
    check("rst_clear", issue_clear, 0);
    check("rst_busy", mul_busy, 0);
    check("rst_cdb", cdb_src_sel, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("post_rst_alu_v", alu_issue_valid, 1);
    check("post_rst_alu_idx", alu_issue_idx, 0);
    check("post_rst_clear", issue_clear, 8'h01);

    // Age select across ROB wrap: head 30, ages 3 / 1 / 31
    @(negedge clk);
    clr_all(); rob_head = 5'd30;
    set_entry(2, 1'b1, 1'b0, 1); set_entry(5, 1'b1, 1'b0, 31); set_entry(6, 1'b1, 1'b0, 29);
    #1;
    check("age_v0", alu_issue_valid, 1);
    check("age_idx0", alu_issue_idx, 5);
    check("age_clear0", issue_clear, 8'h20);
    check("age_cdb_alu", cdb_src_sel, 1);
    @(negedge clk); set_entry(5, 1'b0, 1'b0, 31); #1;
    check("age_idx1", alu_issue_idx, 2);
    @(negedge clk); set_entry(2, 1'b0, 1'b0, 1); #1;
    check("age_idx2", alu_issue_idx, 6);

    // Tie on equal rob index; entry 1 is oldest but rs1 not ready
    @(negedge clk);
    clr_all(); rob_head = '0;
    set_entry(3, 1'b1, 1'b0, 7); set_entry(4, 1'b1, 1'b0, 7); set_entry(1, 1'b1, 1'b0, 0);
    entry_rs1_ready[1] = 1'b0;
    #1;
    check("tie_idx", alu_issue_idx, 3);
    check("tie_clear", issue_clear, 8'h08);

    // No candidates
    @(negedge clk); clr_all(); #1;
    check("idle_alu_v", alu_issue_valid, 0);
    check("idle_alu_idx", alu_issue_idx, 0);
    check("idle_mul_v", mul_issue_valid, 0);
    check("idle_mul_idx", mul_issue_idx, 0);
    check("idle_cdb_prev", cdb_src_sel, 1);
    @(negedge clk); #1;
    check("idle_cdb", cdb_src_sel, 0);

    // MUL sequencing, latency 3
    @(negedge clk); set_entry(0, 1'b1, 1'b1, 4); set_entry(1, 1'b1, 1'b1, 2); #1;
    check("mul_t0_v", mul_issue_valid, 1);
    check("mul_t0_idx", mul_issue_idx, 1);
    check("mul_t0_busy", mul_busy, 0);
    check("mul_t0_alu_v", alu_issue_valid, 0);
    check("mul_t0_clear", issue_clear, 8'h02);
    @(negedge clk); set_entry(1, 1'b0, 1'b1, 2); #1;
    check("mul_t1_v", mul_issue_valid, 0);
    check("mul_t1_busy", mul_busy, 1);
    @(negedge clk); #1;
    check("mul_t2_v", mul_issue_valid, 0);
    check("mul_t2_busy", mul_busy, 1);
    check("mul_t2_cdb", cdb_src_sel, 0);
    @(negedge clk); #1;
    check("mul_t3_v", mul_issue_valid, 1);
    check("mul_t3_idx", mul_issue_idx, 0);
    check("mul_t3_busy", mul_busy, 0);
    check("mul_t3_cdb", cdb_src_sel, 2);
    @(negedge clk); set_entry(0, 1'b0, 1'b1, 4); #1;
    check("mul_t4_busy", mul_busy, 1);
    check("mul_t4_cdb", cdb_src_sel, 0);
    @(negedge clk); #1;
    check("mul_t5_busy", mul_busy, 1);
    check("mul_t5_cdb", cdb_src_sel, 0);
    @(negedge clk); #1;
    check("mul_t6_busy", mul_busy, 0);
    check("mul_t6_cdb", cdb_src_sel, 2);

    // Collision: MUL at c0, ALU entry ready every cycle
    @(negedge clk);
    clr_all(); set_entry(0, 1'b1, 1'b1, 0); set_entry(1, 1'b1, 1'b0, 1);
    #1;
    check("col_c0_mul_v", mul_issue_valid, 1);
    check("col_c0_alu_v", alu_issue_valid, 1);
    check("col_c0_alu_idx", alu_issue_idx, 1);
    check("col_c0_clear", issue_clear, 8'h03);
    @(negedge clk); set_entry(0, 1'b0, 1'b1, 0); #1;
    check("col_c1_alu_v", alu_issue_valid, 1);
    check("col_c1_cdb", cdb_src_sel, 1);
    @(negedge clk); #1;
    check("col_c2_alu_v", alu_issue_valid, 0);
    check("col_c2_clear", issue_clear, 0);
    check("col_c2_cdb", cdb_src_sel, 1);
    @(negedge clk); #1;
    check("col_c3_alu_v", alu_issue_valid, 1);
    check("col_c3_cdb", cdb_src_sel, 2);
    @(negedge clk); clr_all(); #1;
    check("col_c4_cdb", cdb_src_sel, 1);
    @(negedge clk); @(negedge clk);

    // Flush one cycle after a MUL grant
    @(negedge clk); set_entry(2, 1'b1, 1'b1, 5); #1;
    check("fl_f0_mul_v", mul_issue_valid, 1);
    check("fl_f0_mul_idx", mul_issue_idx, 2);
    @(negedge clk); clr_all(); set_entry(3, 1'b1, 1'b0, 6); flush = 1'b1; #1;
    check("fl_f1_alu_v", alu_issue_valid, 0);
    check("fl_f1_mul_v", mul_issue_valid, 0);
    check("fl_f1_clear", issue_clear, 0);
    check("fl_f1_busy", mul_busy, 1);
    @(negedge clk); flush = 1'b0; clr_all(); #1;
    check("fl_f2_busy", mul_busy, 0);
    check("fl_f2_cdb", cdb_src_sel, 0);
    @(negedge clk); #1;
    check("fl_f3_cdb", cdb_src_sel, 0);
    check("fl_f3_busy", mul_busy, 0);

    // Reset in the middle of a multiply
    @(negedge clk); set_entry(2, 1'b1, 1'b1, 5); #1;
    check("rm_r0_mul_v", mul_issue_valid, 1);
    @(negedge clk); clr_all(); rst = 1'b1; #1;
    check("rm_r1_mul_v", mul_issue_valid, 0);
    @(negedge clk); rst = 1'b0; set_entry(4, 1'b1, 1'b1, 9); #1;
    check("rm_r2_busy", mul_busy, 0);
    check("rm_r2_cdb", cdb_src_sel, 0);
    check("rm_r2_mul_v", mul_issue_valid, 1);
    check("rm_r2_mul_idx", mul_issue_idx, 4);
    @(negedge clk); clr_all(); #1;
    check("rm_r3_cdb", cdb_src_sel, 0);
    check("rm_r3_busy", mul_busy, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
